// File: rtl/bitslip_align_pkg.sv
// Shared types and widths for the bitslip alignment controller.
// Optional feature macro used elsewhere in this slice: BITSLIP_ALIGN_ERRCNT_EN.
package bitslip_align_pkg;

    // Per-lane alignment state
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } lane_state_e;

    localparam int unsigned SLIP_TOTAL_W = 8;
    localparam int unsigned ERR_CNT_W    = 16;

    // Bits needed to hold 0..max_val without wrapping
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bitslip_align_ctrl_if.sv
// Lane bus between the deserialiser/sequencer side (master) and the alignment
// controller (slave).
//   enable      master->slave  run alignment
//   data        master->slave  NCH lane words, lane i at [i*WIDTH +: WIDTH]
//   slip        slave->master  per-lane one-cycle bitslip pulse
//   locked      slave->master  per-lane aligned flag
//   fail        slave->master  per-lane slip budget exhausted
//   all_locked  slave->master  every lane locked
//   slip_total  slave->master  per-lane saturating slip count (8 bits each)
//   err_cnt     slave->master  per-lane locked mismatch count (16 bits each),
//                              present only with BITSLIP_ALIGN_ERRCNT_EN
interface bitslip_align_ctrl_if
    import bitslip_align_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 10
);

    logic                          enable;
    logic [NCH*WIDTH-1:0]          data;
    logic [NCH-1:0]                slip;
    logic [NCH-1:0]                locked;
    logic [NCH-1:0]                fail;
    logic                          all_locked;
    logic [NCH*SLIP_TOTAL_W-1:0]   slip_total;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
    logic [NCH*ERR_CNT_W-1:0]      err_cnt;

    modport master (
        output enable, data,
        input  slip, locked, fail, all_locked, slip_total, err_cnt
    );

    modport slave (
        input  enable, data,
        output slip, locked, fail, all_locked, slip_total, err_cnt
    );
`else
    modport master (
        output enable, data,
        input  slip, locked, fail, all_locked, slip_total
    );

    modport slave (
        input  enable, data,
        output slip, locked, fail, all_locked, slip_total
    );
`endif

endinterface

// File: rtl/bitslip_align_lane.sv
// One lane of the word-alignment controller: hunts for PATTERN by pulsing
// slip, waiting SETTLE cycles after each slip, and declares lock / loss / fail.
// Ports:
//   clk, resetn  word clock, async active-low reset
//   enable       run alignment (0 forces IDLE next cycle)
//   data         this lane's deserialised word
//   slip         one-cycle bitslip pulse (registered)
//   locked       lane aligned (registered)
//   fail         MAX_SLIP exhausted without lock (registered)
//   slip_total   slips since enable rose, saturating
//   err_cnt      mismatches while locked, saturating (BITSLIP_ALIGN_ERRCNT_EN only)
module bitslip_align_lane
    import bitslip_align_pkg::*;
#(
    parameter int unsigned     WIDTH    = 10,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(10'h01F),
    parameter int unsigned     SETTLE   = 16,
    parameter int unsigned     LOCK_CNT = 8,
    parameter int unsigned     LOSS_CNT = 4,
    parameter int unsigned     MAX_SLIP = 2 * WIDTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [WIDTH-1:0]        data,
    output logic                    slip,
    output logic                    locked,
    output logic                    fail,
`ifdef BITSLIP_ALIGN_ERRCNT_EN
    output logic [ERR_CNT_W-1:0]    err_cnt,
`endif
    output logic [SLIP_TOTAL_W-1:0] slip_total
);

    localparam int unsigned SETTLE_W = cnt_w(SETTLE);
    localparam int unsigned MATCH_W  = cnt_w(LOCK_CNT);
    localparam int unsigned LOSS_W   = cnt_w(LOSS_CNT);
    localparam int unsigned NSLIP_W  = cnt_w(MAX_SLIP);

    lane_state_e               state_q, state_d;
    logic [SETTLE_W-1:0]       settle_q, settle_d;
    logic [MATCH_W-1:0]        match_q, match_d;
    logic [LOSS_W-1:0]         loss_q, loss_d;
    logic [NSLIP_W-1:0]        nslip_q, nslip_d;
    logic [SLIP_TOTAL_W-1:0]   slip_total_q, slip_total_d;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
    logic [ERR_CNT_W-1:0]      err_q, err_d;
`endif
    logic                      is_match;

    assign is_match = (data == PATTERN);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            match_q      <= '0;
            loss_q       <= '0;
            nslip_q      <= '0;
            slip_total_q <= '0;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
            err_q        <= '0;
`endif
            slip         <= 1'b0;
            locked       <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            match_q      <= match_d;
            loss_q       <= loss_d;
            nslip_q      <= nslip_d;
            slip_total_q <= slip_total_d;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
            err_q        <= err_d;
`endif
            // Flags decode the next state so they line up with the state itself
            slip         <= (state_d == SLIP);
            locked       <= (state_d == LOCKED);
            fail         <= (state_d == FAIL);
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        match_d      = match_q;
        loss_d       = loss_q;
        nslip_d      = nslip_q;
        slip_total_d = slip_total_q;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
        err_d        = err_q;
`endif

        if (!enable) begin
            // Disable wins over everything; slip_total is kept for inspection
            state_d  = IDLE;
            settle_d = '0;
            match_d  = '0;
            loss_d   = '0;
            nslip_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = WAIT;
                    settle_d     = SETTLE_W'(SETTLE - 1);
                    match_d      = '0;
                    loss_d       = '0;
                    nslip_d      = '0;
                    slip_total_d = '0;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
                    err_d        = '0;
`endif
                end

                WAIT: begin
                    if (settle_q == '0) begin
                        state_d = CHECK;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end

                CHECK: begin
                    if (is_match) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            loss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        // Budget is checked before counting, so MAX_SLIP slips are issued
                        if (nslip_q == NSLIP_W'(MAX_SLIP)) begin
                            state_d = FAIL;
                        end else begin
                            nslip_d = nslip_q + NSLIP_W'(1);
                            state_d = SLIP;
                        end
                    end
                end

                SLIP: begin
                    state_d  = WAIT;
                    settle_d = SETTLE_W'(SETTLE - 1);
                    if (slip_total_q != '1) begin
                        slip_total_d = slip_total_q + SLIP_TOTAL_W'(1);
                    end
                end

                LOCKED: begin
                    if (is_match) begin
                        loss_d = '0;
                    end else begin
`ifdef BITSLIP_ALIGN_ERRCNT_EN
                        if (err_q != '1) begin
                            err_d = err_q + ERR_CNT_W'(1);
                        end
`endif
                        if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
                            // Lost alignment: re-hunt from a fresh settle interval
                            state_d  = WAIT;
                            settle_d = SETTLE_W'(SETTLE - 1);
                            loss_d   = '0;
                            match_d  = '0;
                            nslip_d  = '0;
                        end else begin
                            loss_d = loss_q + LOSS_W'(1);
                        end
                    end
                end

                FAIL: begin
                    state_d = FAIL;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign slip_total = slip_total_q;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
    assign err_cnt    = err_q;
`endif

endmodule

// File: rtl/bitslip_align_ctrl.sv
// Multi-lane word-alignment controller: one bitslip_align_lane per deserialiser
// lane plus the registered all_locked reduction.
// Ports:
//   clk     deserialiser word clock
//   resetn  asynchronous active-low reset
//   bus     bitslip_align_ctrl_if.slave (enable, data in; slip, locked, fail,
//           all_locked, slip_total and optional err_cnt out)
// Optional feature: define BITSLIP_ALIGN_ERRCNT_EN to add per-lane err_cnt.
module bitslip_align_ctrl
    import bitslip_align_pkg::*;
#(
    parameter int unsigned      NCH      = 4,
    parameter int unsigned      WIDTH    = 10,
    parameter logic [WIDTH-1:0] PATTERN  = WIDTH'(10'h01F),
    parameter int unsigned      SETTLE   = 16,
    parameter int unsigned      LOCK_CNT = 8,
    parameter int unsigned      LOSS_CNT = 4,
    parameter int unsigned      MAX_SLIP = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    bitslip_align_ctrl_if.slave  bus
);

    logic [NCH-1:0]              slip_w;
    logic [NCH-1:0]              locked_w;
    logic [NCH-1:0]              fail_w;
    logic [NCH*SLIP_TOTAL_W-1:0] slip_total_w;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
    logic [NCH*ERR_CNT_W-1:0]    err_cnt_w;
`endif
    logic                        all_locked_q;

    // Independent per-lane aligners
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        bitslip_align_lane #(
            .WIDTH    (WIDTH),
            .PATTERN  (PATTERN),
            .SETTLE   (SETTLE),
            .LOCK_CNT (LOCK_CNT),
            .LOSS_CNT (LOSS_CNT),
            .MAX_SLIP (MAX_SLIP)
        ) u_lane (
            .clk        (clk),
            .resetn     (resetn),
            .enable     (bus.enable),
            .data       (bus.data[i*WIDTH +: WIDTH]),
            .slip       (slip_w[i]),
            .locked     (locked_w[i]),
            .fail       (fail_w[i]),
`ifdef BITSLIP_ALIGN_ERRCNT_EN
            .err_cnt    (err_cnt_w[i*ERR_CNT_W +: ERR_CNT_W]),
`endif
            .slip_total (slip_total_w[i*SLIP_TOTAL_W +: SLIP_TOTAL_W])
        );
    end

    // all_locked follows the registered lane flags by one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= &locked_w;
        end
    end

    assign bus.slip       = slip_w;
    assign bus.locked     = locked_w;
    assign bus.fail       = fail_w;
    assign bus.all_locked = all_locked_q;
    assign bus.slip_total = slip_total_w;
`ifdef BITSLIP_ALIGN_ERRCNT_EN
    assign bus.err_cnt    = err_cnt_w;
`endif

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Self-checking bench for bitslip_align_ctrl with a rotating-deserialiser lane
// model. Expected slip times are queued when a hunt starts and matched against
// observed slip pulses. Define BITSLIP_ALIGN_ERRCNT_EN to also exercise err_cnt.
module tb_bitslip_align_ctrl;

    localparam int unsigned      NCH      = 4;
    localparam int unsigned      WIDTH    = 10;
    localparam logic [WIDTH-1:0] PATTERN  = 10'h01F;
    localparam int unsigned      SETTLE   = 16;
    localparam int unsigned      LOCK_CNT = 8;
    localparam int unsigned      LOSS_CNT = 4;
    localparam int unsigned      MAX_SLIP = 2 * WIDTH;
    localparam int               SLIP_GAP = SETTLE + 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    bitslip_align_ctrl_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    bitslip_align_ctrl #(
        .NCH      (NCH),
        .WIDTH    (WIDTH),
        .PATTERN  (PATTERN),
        .SETTLE   (SETTLE),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .MAX_SLIP (MAX_SLIP)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int   off [NCH];
    logic bad [NCH];

    int exp_q  [NCH][$];
    int obs_q  [NCH][$];
    int lock_q [NCH][$];
    int fail_q [NCH][$];
    int all_q  [$];

    logic [NCH-1:0] prev_locked = '0;
    logic [NCH-1:0] prev_fail   = '0;
    logic           prev_all    = 1'b0;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w, input int n);
        logic [WIDTH-1:0] r;
        r = w;
        for (int k = 0; k < n; k++) r = {r[WIDTH-2:0], r[WIDTH-1]};
        return r;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NCH; i++)
            bus.data[i*WIDTH +: WIDTH] = bad[i] ? ~PATTERN : rotl(PATTERN, off[i]);
    endtask

    // Advance one clock, apply the deserialiser model and record output events
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            if (bus.slip[i]) begin
                obs_q[i].push_back(cyc);
                off[i] = (off[i] + 1) % WIDTH;
            end
            if (bus.locked[i] && !prev_locked[i]) lock_q[i].push_back(cyc);
            if (bus.fail[i] && !prev_fail[i])     fail_q[i].push_back(cyc);
        end
        if (bus.all_locked && !prev_all) all_q.push_back(cyc);
        prev_locked = bus.locked;
        prev_fail   = bus.fail;
        prev_all    = bus.all_locked;
        drive_data();
    endtask

    task automatic clear_sb();
        for (int i = 0; i < NCH; i++) begin
            exp_q[i].delete();
            obs_q[i].delete();
            lock_q[i].delete();
            fail_q[i].delete();
        end
        all_q.delete();
    endtask

    // Set lane rotations, raise enable and queue the expected slip times
    task automatic start_hunt(input int rot [NCH], input logic [NCH-1:0] bad_m, output int e);
        int n;
        e = cyc + 1;
        for (int i = 0; i < NCH; i++) begin
            bad[i] = bad_m[i];
            off[i] = (WIDTH - rot[i]) % WIDTH;
            n = bad_m[i] ? int'(MAX_SLIP) : rot[i];
            for (int j = 0; j < n; j++)
                exp_q[i].push_back(e + SETTLE + 1 + j * SLIP_GAP);
        end
        drive_data();
        bus.enable = 1'b1;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        bus.enable = 1'b0;
        for (int i = 0; i < NCH; i++) begin off[i] = 0; bad[i] = 1'b0; end
        drive_data();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (bus.slip !== '0) begin errors++; $display("FAIL reset_slip: got %b expected 0", bus.slip); end
        checks++;
        if (bus.locked !== '0) begin errors++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
        checks++;
        if (bus.fail !== '0) begin errors++; $display("FAIL reset_fail: got %b expected 0", bus.fail); end
        checks++;
        if (bus.all_locked !== 1'b0) begin errors++; $display("FAIL reset_all_locked: got %b expected 0", bus.all_locked); end
        checks++;
        if (bus.slip_total !== '0) begin errors++; $display("FAIL reset_slip_total: got %h expected 0", bus.slip_total); end
    endtask

    // Lane0 aligned, lane1 rotation 3, lane2 never matches, lane3 rotation 1
    task automatic test_hunt();
        int rot [NCH];
        int e, ex, ob, fail_at;
        int exp_lock [NCH];
        logic [NCH*8-1:0] exp_st;
        clear_sb();
        rot = '{0, 3, 0, 1};
        start_hunt(rot, 4'b0100, e);
        fail_at = e + SETTLE + 1 + MAX_SLIP * SLIP_GAP;
        while (cyc < fail_at + 3) tick();

        for (int i = 0; i < NCH; i++) begin
            while (exp_q[i].size() > 0) begin
                ex = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL hunt_slip lane%0d: got no pulse expected cycle %0d", i, ex);
                end else begin
                    ob = obs_q[i].pop_front();
                    if (ob !== ex) begin errors++; $display("FAIL hunt_slip lane%0d: got cycle %0d expected %0d", i, ob, ex); end
                end
            end
            checks++;
            if (obs_q[i].size() != 0) begin
                errors++; $display("FAIL hunt_stray_slip lane%0d: got %0d extra expected 0", i, obs_q[i].size());
            end
        end

        exp_lock = '{e + SETTLE + LOCK_CNT, e + SETTLE + LOCK_CNT + 3 * SLIP_GAP, 0,
                     e + SETTLE + LOCK_CNT + SLIP_GAP};
        for (int i = 0; i < NCH; i++) begin
            if (i == 2) continue;
            checks++;
            if (lock_q[i].size() == 0) begin
                errors++; $display("FAIL hunt_lock lane%0d: got none expected cycle %0d", i, exp_lock[i]);
            end else begin
                ob = lock_q[i].pop_front();
                if (ob !== exp_lock[i]) begin errors++; $display("FAIL hunt_lock lane%0d: got cycle %0d expected %0d", i, ob, exp_lock[i]); end
            end
        end
        checks++;
        if (fail_q[2].size() == 0) begin
            errors++; $display("FAIL hunt_fail_time: got none expected cycle %0d", fail_at);
        end else begin
            ob = fail_q[2].pop_front();
            if (ob !== fail_at) begin errors++; $display("FAIL hunt_fail_time: got cycle %0d expected %0d", ob, fail_at); end
        end
        checks++;
        if (bus.locked !== 4'b1011) begin errors++; $display("FAIL hunt_locked: got %b expected 1011", bus.locked); end
        checks++;
        if (bus.fail !== 4'b0100) begin errors++; $display("FAIL hunt_fail: got %b expected 0100", bus.fail); end
        checks++;
        if (bus.all_locked !== 1'b0) begin errors++; $display("FAIL hunt_all_locked: got %b expected 0", bus.all_locked); end
        exp_st = '0;
        exp_st[1*8 +: 8] = 8'd3;
        exp_st[2*8 +: 8] = 8'(MAX_SLIP);
        exp_st[3*8 +: 8] = 8'd1;
        checks++;
        if (bus.slip_total !== exp_st) begin errors++; $display("FAIL hunt_slip_total: got %h expected %h", bus.slip_total, exp_st); end
    endtask

    task automatic test_fail_clear();
        logic [NCH*8-1:0] held;
        held = bus.slip_total;
        bus.enable = 1'b0;
        tick();
        checks++;
        if (bus.fail !== '0) begin errors++; $display("FAIL disable_fail: got %b expected 0", bus.fail); end
        checks++;
        if (bus.locked !== '0) begin errors++; $display("FAIL disable_locked: got %b expected 0", bus.locked); end
        checks++;
        if (bus.slip_total !== held) begin errors++; $display("FAIL disable_slip_total: got %h expected %h", bus.slip_total, held); end
        for (int k = 0; k < 5; k++) tick();
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (obs_q[i].size() != 0) begin errors++; $display("FAIL disable_stray_slip lane%0d: got %0d expected 0", i, obs_q[i].size()); end
        end
    endtask

    // enable drop mid-settle, then asynchronous reset mid-hunt
    task automatic test_abort();
        int rot [NCH];
        int e, e2, e3, ex, ob;
        logic [NCH*8-1:0] ones;
        clear_sb();
        ones = {NCH{8'd1}};
        rot = '{3, 3, 3, 3};
        start_hunt(rot, 4'b0000, e);
        while (cyc < e + SETTLE + 6) tick();
        bus.enable = 1'b0;
        for (int i = 0; i < NCH; i++)
            while (exp_q[i].size() > 0 && exp_q[i][$] > cyc) void'(exp_q[i].pop_back());
        tick();
        checks++;
        if ({bus.slip, bus.locked, bus.fail} !== '0) begin
            errors++; $display("FAIL abort_flags: got %b/%b/%b expected 0", bus.slip, bus.locked, bus.fail);
        end
        checks++;
        if (bus.slip_total !== ones) begin errors++; $display("FAIL abort_slip_total: got %h expected %h", bus.slip_total, ones); end
        for (int k = 0; k < 20; k++) tick();

        rot = '{2, 2, 2, 2};
        start_hunt(rot, 4'b0000, e2);
        tick();
        checks++;
        if (bus.slip_total !== '0) begin errors++; $display("FAIL restart_clear: got %h expected 0", bus.slip_total); end
        while (cyc < e2 + SETTLE + 4) tick();
        resetn = 1'b0;
        #2;
        checks++;
        if ({bus.slip, bus.locked, bus.fail, bus.all_locked} !== '0 || bus.slip_total !== '0) begin
            errors++; $display("FAIL async_reset: got %b/%b/%b/%b/%h expected 0", bus.slip, bus.locked, bus.fail, bus.all_locked, bus.slip_total);
        end
        #2;
        resetn = 1'b1;
        for (int i = 0; i < NCH; i++)
            while (exp_q[i].size() > 0 && exp_q[i][$] > cyc) void'(exp_q[i].pop_back());
        rot = '{1, 1, 1, 1};
        start_hunt(rot, 4'b0000, e3);
        while (cyc < e3 + SETTLE + LOCK_CNT + SLIP_GAP + 3) tick();

        for (int i = 0; i < NCH; i++) begin
            while (exp_q[i].size() > 0) begin
                ex = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL abort_slip lane%0d: got no pulse expected cycle %0d", i, ex);
                end else begin
                    ob = obs_q[i].pop_front();
                    if (ob !== ex) begin errors++; $display("FAIL abort_slip lane%0d: got cycle %0d expected %0d", i, ob, ex); end
                end
            end
            checks++;
            if (obs_q[i].size() != 0) begin errors++; $display("FAIL abort_stray_slip lane%0d: got %0d extra expected 0", i, obs_q[i].size()); end
        end
        checks++;
        if (bus.locked !== '1 || bus.slip_total !== ones) begin
            errors++; $display("FAIL abort_relock: got %b/%h expected 1111/%h", bus.locked, bus.slip_total, ones);
        end
    endtask

    // Lanes at rotations 0,2,5,9 and the all_locked timing
    task automatic test_all_lanes();
        int rot [NCH];
        int e, ex, ob, last;
        logic [NCH*8-1:0] exp_st;
        bus.enable = 1'b0;
        tick();
        tick();
        clear_sb();
        rot = '{0, 2, 5, 9};
        start_hunt(rot, 4'b0000, e);
        last = e + SETTLE + LOCK_CNT + 9 * SLIP_GAP;
        while (cyc < last + 4) tick();
        for (int i = 0; i < NCH; i++) begin
            ex = e + SETTLE + LOCK_CNT + rot[i] * SLIP_GAP;
            checks++;
            if (lock_q[i].size() == 0) begin
                errors++; $display("FAIL all_lock lane%0d: got none expected cycle %0d", i, ex);
            end else begin
                ob = lock_q[i].pop_front();
                if (ob !== ex) begin errors++; $display("FAIL all_lock lane%0d: got cycle %0d expected %0d", i, ob, ex); end
            end
            while (exp_q[i].size() > 0) begin
                ex = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL all_slip lane%0d: got no pulse expected cycle %0d", i, ex);
                end else begin
                    ob = obs_q[i].pop_front();
                    if (ob !== ex) begin errors++; $display("FAIL all_slip lane%0d: got cycle %0d expected %0d", i, ob, ex); end
                end
            end
        end
        checks++;
        if (all_q.size() == 0) begin
            errors++; $display("FAIL all_locked_time: got none expected cycle %0d", last + 1);
        end else begin
            ob = all_q.pop_front();
            if (ob !== last + 1) begin errors++; $display("FAIL all_locked_time: got cycle %0d expected %0d", ob, last + 1); end
        end
        exp_st = {8'd9, 8'd5, 8'd2, 8'd0};
        checks++;
        if (bus.slip_total !== exp_st) begin errors++; $display("FAIL all_slip_total: got %h expected %h", bus.slip_total, exp_st); end
`ifdef BITSLIP_ALIGN_ERRCNT_EN
        for (int k = 0; k < 4; k++) begin
            bad[3] = (k % 2 == 0);
            drive_data();
            tick();
        end
        bad[3] = 1'b0;
        drive_data();
        tick();
        checks++;
        if (bus.err_cnt !== {16'd2, 16'd0, 16'd0, 16'd0}) begin
            errors++; $display("FAIL err_cnt: got %h expected 0002000000000000", bus.err_cnt);
        end
        checks++;
        if (bus.locked !== '1) begin errors++; $display("FAIL err_cnt_locked: got %b expected 1111", bus.locked); end
`endif
    endtask

    // 3 mismatches, a match, 4 mismatches on locked lane0, then relock
    task automatic test_loss_relock();
        logic seq [8];
        logic exp_l;
        int d, ob;
        clear_sb();
        seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            bad[0] = seq[k];
            drive_data();
            tick();
            exp_l = (k < 7);
            checks++;
            if (bus.locked[0] !== exp_l) begin errors++; $display("FAIL loss_locked step%0d: got %b expected %b", k, bus.locked[0], exp_l); end
        end
        d = cyc;
        bad[0] = 1'b0;
        drive_data();
        while (cyc < d + SETTLE + LOCK_CNT + 3) tick();
        checks++;
        if (lock_q[0].size() == 0) begin
            errors++; $display("FAIL relock_time: got none expected cycle %0d", d + SETTLE + LOCK_CNT);
        end else begin
            ob = lock_q[0].pop_front();
            if (ob !== d + SETTLE + LOCK_CNT) begin errors++; $display("FAIL relock_time: got cycle %0d expected %0d", ob, d + SETTLE + LOCK_CNT); end
        end
        checks++;
        if (bus.fail !== '0 || obs_q[0].size() != 0) begin
            errors++; $display("FAIL relock_clean: got fail %b slips %0d expected 0", bus.fail, obs_q[0].size());
        end
        checks++;
        if (bus.all_locked !== 1'b1) begin errors++; $display("FAIL relock_all_locked: got %b expected 1", bus.all_locked); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0;
        bus.data   = '0;
        test_reset();
        test_hunt();
        test_fail_clear();
        test_abort();
        test_all_lanes();
        test_loss_relock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
